// File: rtl/aes_cp_pkg.sv
// Shared constants and FSM state encoding for the AES data-copy engine.
package aes_cp_pkg;

    localparam int WORDS_PER_BLK = 4;
    localparam int BYTES_PER_BLK = 16;
    localparam int MAX_BLOCKS    = 128;
    localparam int BLK_W         = $clog2(MAX_BLOCKS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        AES_REQ,
        AES_WAIT,
        WR,
        DONE
    } cpState_e;

endpackage

// File: rtl/aes_dt_cp_if.sv
// Handshake bundle between the copy engine (master) and the AES core (slave).
interface aes_dt_cp_if;
    logic         oAesInVld;
    logic         iAesInRdy;
    logic [127:0] oAesInDt;
    logic         iAesOutVld;
    logic [127:0] iAesOutDt;

    modport master (
        output oAesInVld,
        output oAesInDt,
        input  iAesInRdy,
        input  iAesOutVld,
        input  iAesOutDt
    );

    modport slave (
        input  oAesInVld,
        input  oAesInDt,
        output iAesInRdy,
        output iAesOutVld,
        output iAesOutDt
    );
endinterface

// File: rtl/aes_cp_word_pack.sv
// Collects four 32-bit InBuf words into one 128-bit AES block (word k at bits 32k+31:32k).
module aes_cp_word_pack
    import aes_cp_pkg::*;
(
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iCapEn,
    input  logic [1:0]   iIdx,
    input  logic [31:0]  iDt,
    output logic [127:0] oBlk
);

    logic [31:0] wordReg [WORDS_PER_BLK];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLK; gi++) begin : gWord
            always_ff @(posedge iClk or negedge iRsn) begin
                if (!iRsn) begin
                    wordReg[gi] <= '0;
                end else if (iCapEn && (iIdx == 2'(gi))) begin
                    wordReg[gi] <= iDt;
                end
            end
            assign oBlk[32*gi +: 32] = wordReg[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_dt_cp.sv
// AES data-copy engine: InBuf -> AES core -> OutBuf, one 16-byte block at a time.
// Optional build macro CP_BYPASS_EN adds iBypass to copy InBuf straight to OutBuf.
module aes_dt_cp
    import aes_cp_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int SIZE_W = 12
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStCp,
    input  logic [SIZE_W-1:0] iCpByteSize,
`ifdef CP_BYPASS_EN
    input  logic              iBypass,
`endif
    output logic              oCpDone,
    output logic              oBusy,
    output logic              oRdEn_InBuf,
    output logic [ADDR_W-1:0] oRdAddr_InBuf,
    input  logic [31:0]       iRdDt_InBuf,
    output logic              oWrEn_OutBuf,
    output logic [ADDR_W-1:0] oWrAddr_OutBuf,
    output logic [31:0]       oWrDt_OutBuf,
    aes_dt_cp_if.master       aesIf
);

    cpState_e          stateReg, stateNext;
    logic [BLK_W-1:0]  blkIdxReg, blkIdxNext;
    logic [BLK_W-1:0]  blkTotReg, blkTotNext;
    logic [2:0]        cntReg, cntNext;
    logic [127:0]      outBlkReg, outBlkNext;

    logic              rdEn, wrEn, aesVld, capEn, done;
    logic              bypassSel;
    logic [127:0]      packBlk;
    logic [127:0]      wrSrc;
    logic [31:0]       wrWord;
    logic [ADDR_W-1:0] wordAddr;
    logic [SIZE_W:0]   sizeRound;
    logic [BLK_W-1:0]  blkCalc;

    // Round up to whole blocks; anything beyond the buffer capacity saturates.
    assign sizeRound = {1'b0, iCpByteSize} + (SIZE_W+1)'(BYTES_PER_BLK - 1);
    assign blkCalc   = ({1'b0, iCpByteSize} > (SIZE_W+1)'(MAX_BLOCKS * BYTES_PER_BLK))
                     ? BLK_W'(MAX_BLOCKS)
                     : BLK_W'(sizeRound >> $clog2(BYTES_PER_BLK));

`ifdef CP_BYPASS_EN
    logic bypassReg;
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            bypassReg <= 1'b0;
        end else if ((stateReg == IDLE) && iStCp) begin
            bypassReg <= iBypass;
        end
    end
    assign bypassSel = bypassReg;
`else
    assign bypassSel = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            stateReg  <= IDLE;
            blkIdxReg <= '0;
            blkTotReg <= '0;
            cntReg    <= '0;
            outBlkReg <= '0;
        end else begin
            stateReg  <= stateNext;
            blkIdxReg <= blkIdxNext;
            blkTotReg <= blkTotNext;
            cntReg    <= cntNext;
            outBlkReg <= outBlkNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        blkIdxNext = blkIdxReg;
        blkTotNext = blkTotReg;
        cntNext    = cntReg;
        outBlkNext = outBlkReg;
        rdEn       = 1'b0;
        wrEn       = 1'b0;
        aesVld     = 1'b0;
        capEn      = 1'b0;
        done       = 1'b0;
        case (stateReg)
            IDLE: begin
                if (iStCp) begin
                    blkTotNext = blkCalc;
                    blkIdxNext = '0;
                    cntNext    = '0;
                    stateNext  = (blkCalc == '0) ? DONE : RD;
                end
            end
            RD: begin
                // cnt 0..3 issue reads; cnt 1..4 capture the word read one cycle earlier.
                rdEn    = ~cntReg[2];
                capEn   = (cntReg != 3'd0);
                cntNext = cntReg + 3'd1;
                if (cntReg == 3'd4) begin
                    cntNext   = '0;
                    stateNext = bypassSel ? WR : AES_REQ;
                end
            end
            AES_REQ: begin
                aesVld = 1'b1;
                if (aesIf.iAesInRdy) begin
                    stateNext = AES_WAIT;
                end
            end
            AES_WAIT: begin
                if (aesIf.iAesOutVld) begin
                    outBlkNext = aesIf.iAesOutDt;
                    stateNext  = WR;
                end
            end
            WR: begin
                wrEn    = 1'b1;
                cntNext = cntReg + 3'd1;
                if (cntReg == 3'd3) begin
                    cntNext    = '0;
                    blkIdxNext = blkIdxReg + BLK_W'(1);
                    stateNext  = ((blkIdxReg + BLK_W'(1)) < blkTotReg) ? RD : DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    aes_cp_word_pack uWordPack (
        .iClk   (iClk),
        .iRsn   (iRsn),
        .iCapEn (capEn),
        .iIdx   (2'(cntReg - 3'd1)),
        .iDt    (iRdDt_InBuf),
        .oBlk   (packBlk)
    );

    assign wordAddr = ADDR_W'({blkIdxReg, cntReg[1:0]});
    assign wrSrc    = bypassSel ? packBlk : outBlkReg;
    assign wrWord   = wrSrc[{cntReg[1:0], 5'b0} +: 32];

    assign oCpDone         = done;
    assign oBusy           = (stateReg != IDLE) && (stateReg != DONE);
    assign oRdEn_InBuf     = rdEn;
    assign oRdAddr_InBuf   = rdEn ? wordAddr : '0;
    assign oWrEn_OutBuf    = wrEn;
    assign oWrAddr_OutBuf  = wrEn ? wordAddr : '0;
    assign oWrDt_OutBuf    = wrEn ? wrWord : '0;
    assign aesIf.oAesInVld = aesVld;
    assign aesIf.oAesInDt  = aesVld ? packBlk : '0;

endmodule

// File: tb/tb_aes_dt_cp.sv
// Directed bench for aes_dt_cp: size table plus handshake-stall and mid-copy reset sequences.
module tb_aes_dt_cp;

    localparam int ADDR_W = 9;
    localparam int SIZE_W = 12;

    logic              iClk = 1'b0;
    logic              iRsn = 1'b0;
    logic              iStCp = 1'b0;
    logic [SIZE_W-1:0] iCpByteSize = '0;
    logic              oCpDone, oBusy;
    logic              oRdEn_InBuf, oWrEn_OutBuf;
    logic [ADDR_W-1:0] oRdAddr_InBuf, oWrAddr_OutBuf;
    logic [31:0]       iRdDt_InBuf = '0;
    logic [31:0]       oWrDt_OutBuf;

    aes_dt_cp_if aesIf ();

    aes_dt_cp #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
        .iClk           (iClk),
        .iRsn           (iRsn),
        .iStCp          (iStCp),
        .iCpByteSize    (iCpByteSize),
`ifdef CP_BYPASS_EN
        .iBypass        (1'b0),
`endif
        .oCpDone        (oCpDone),
        .oBusy          (oBusy),
        .oRdEn_InBuf    (oRdEn_InBuf),
        .oRdAddr_InBuf  (oRdAddr_InBuf),
        .iRdDt_InBuf    (iRdDt_InBuf),
        .oWrEn_OutBuf   (oWrEn_OutBuf),
        .oWrAddr_OutBuf (oWrAddr_OutBuf),
        .oWrDt_OutBuf   (oWrDt_OutBuf),
        .aesIf          (aesIf.master)
    );

    always #5 iClk = ~iClk;

    logic [31:0] inBuf  [512];
    logic [31:0] outBuf [512];
    int errors = 0;
    int checks = 0;

    // InBuf model with one-cycle read latency
    always @(posedge iClk) begin
        if (oRdEn_InBuf) iRdDt_InBuf <= inBuf[oRdAddr_InBuf];
    end

    // AES core model: returns input XOR all-ones a few cycles after acceptance
    logic         rdyEn = 1'b1;
    logic [127:0] aesResp = '0;
    int           aesDly = 0;
    assign aesIf.iAesInRdy = rdyEn;
    initial begin
        aesIf.iAesOutVld = 1'b0;
        aesIf.iAesOutDt  = '0;
    end
    always @(posedge iClk) begin
        aesIf.iAesOutVld <= 1'b0;
        if (aesIf.oAesInVld && aesIf.iAesInRdy) begin
            aesResp <= ~aesIf.oAesInDt;
            aesDly  <= 3;
        end else if (aesDly != 0) begin
            aesDly <= aesDly - 1;
            if (aesDly == 1) begin
                aesIf.iAesOutVld <= 1'b1;
                aesIf.iAesOutDt  <= aesResp;
            end
        end
    end

    // Bus monitor, sampled mid-cycle
    logic clrMon = 1'b0;
    int   cyc = 0, doneCyc = 0;
    int   rdCnt = 0, wrCnt = 0, doneCnt = 0, vldCnt = 0, overlap = 0;
    int   lastWr = 0;
    always @(posedge iClk) cyc <= cyc + 1;
    always @(negedge iClk) begin
        if (clrMon) begin
            rdCnt <= 0; wrCnt <= 0; doneCnt <= 0; vldCnt <= 0; overlap <= 0; lastWr <= 0;
            for (int i = 0; i < 512; i++) outBuf[i] <= '0;
        end else begin
            if (oRdEn_InBuf) rdCnt <= rdCnt + 1;
            if (oWrEn_OutBuf) begin
                wrCnt <= wrCnt + 1;
                lastWr <= int'(oWrAddr_OutBuf);
                outBuf[oWrAddr_OutBuf] <= oWrDt_OutBuf;
            end
            if (oRdEn_InBuf && oWrEn_OutBuf) overlap <= overlap + 1;
            if (aesIf.oAesInVld) vldCnt <= vldCnt + 1;
            if (oCpDone) begin
                doneCnt <= doneCnt + 1;
                doneCyc <= cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearMon();
        @(negedge iClk); #1 clrMon = 1'b1;
        @(negedge iClk); #1 clrMon = 1'b0;
    endtask

    int startCyc = 0;
    task automatic startCp(input int size);
        @(negedge iClk);
        iStCp = 1'b1;
        iCpByteSize = SIZE_W'(size);
        startCyc = cyc;
        @(negedge iClk);
        iStCp = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (doneCnt == 0 && n < 6000) begin
            @(negedge iClk); #1;
            n++;
        end
        if (doneCnt == 0) check({name, "_timeout"}, 32'd0, 32'd1);
        repeat (5) @(negedge iClk);
        #1;
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_done"},   {31'd0, oCpDone},          32'd0);
        check({tag, "_busy"},   {31'd0, oBusy},            32'd0);
        check({tag, "_rden"},   {31'd0, oRdEn_InBuf},      32'd0);
        check({tag, "_wren"},   {31'd0, oWrEn_OutBuf},     32'd0);
        check({tag, "_vld"},    {31'd0, aesIf.oAesInVld},  32'd0);
        check({tag, "_rdaddr"}, 32'(oRdAddr_InBuf),        32'd0);
        check({tag, "_wraddr"}, 32'(oWrAddr_OutBuf),       32'd0);
        check({tag, "_wrdt"},   oWrDt_OutBuf,              32'd0);
        check({tag, "_aesdt"},  32'(|aesIf.oAesInDt),      32'd0);
    endtask

    typedef struct {
        int size;
        int expWords;
        int expLast;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [127:0] snap;
        int unstable, bad, n;

        vecs[0] = '{16,   4,   3};
        vecs[1] = '{33,   12,  11};
        vecs[2] = '{1,    4,   3};
        vecs[3] = '{17,   8,   7};
        vecs[4] = '{2048, 512, 511};
        vecs[5] = '{4095, 512, 511};
        vecs[6] = '{0,    0,   0};

        for (int i = 0; i < 512; i++) inBuf[i] = 32'hA5000000 + i * 32'h00010003;
        inBuf[0] = 32'h11111111; inBuf[1] = 32'h22222222;
        inBuf[2] = 32'h33333333; inBuf[3] = 32'h44444444;

        repeat (3) @(negedge iClk);
        #1 checkOutputsZero("rst_hold");
        iRsn = 1'b1;
        clearMon();
        #1 checkOutputsZero("post_rst");

        for (int v = 0; v < 7; v++) begin
            clearMon();
            startCp(vecs[v].size);
            waitDone($sformatf("v%0d", v));
            bad = 0;
            for (int a = 0; a < vecs[v].expWords; a++)
                if (outBuf[a] !== ~inBuf[a]) bad++;
            $display("txn size=%0d reads=%0d writes=%0d last=%0d done=%0d badwords=%0d",
                     vecs[v].size, rdCnt, wrCnt, lastWr, doneCnt, bad);
            check($sformatf("v%0d_donecnt", v), 32'(doneCnt), 32'd1);
            check($sformatf("v%0d_reads", v),   32'(rdCnt),   32'(vecs[v].expWords));
            check($sformatf("v%0d_writes", v),  32'(wrCnt),   32'(vecs[v].expWords));
            check($sformatf("v%0d_overlap", v), 32'(overlap), 32'd0);
            if (vecs[v].expWords > 0) begin
                check($sformatf("v%0d_lastaddr", v), 32'(lastWr), 32'(vecs[v].expLast));
                check($sformatf("v%0d_data", v),     32'(bad),    32'd0);
            end else begin
                check("zero_vld", 32'(vldCnt), 32'd0);
                check("zero_latency_le2", 32'(doneCyc - startCyc <= 2), 32'd1);
            end
        end

        // Stalled AES acceptance with a stray start while busy
        clearMon();
        rdyEn = 1'b0;
        startCp(33);
        n = 0;
        while (!aesIf.oAesInVld && n < 50) begin @(negedge iClk); #1; n++; end
        check("stall_vld_seen", {31'd0, aesIf.oAesInVld}, 32'd1);
        snap = aesIf.oAesInDt;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iClk);
            iStCp = (c == 3);
            iCpByteSize = 12'd16;
            #1;
            if (!aesIf.oAesInVld || aesIf.oAesInDt !== snap) unstable++;
        end
        iStCp = 1'b0;
        check("stall_stable", 32'(unstable), 32'd0);
        check("pack_w0", snap[31:0],   32'h11111111);
        check("pack_w3", snap[127:96], 32'h44444444);
        rdyEn = 1'b1;
        waitDone("stall");
        $display("txn stall size=33 reads=%0d writes=%0d done=%0d", rdCnt, wrCnt, doneCnt);
        check("stall_donecnt", 32'(doneCnt), 32'd1);
        check("stall_writes",  32'(wrCnt),   32'd12);
        check("stall_busy_after", {31'd0, oBusy}, 32'd0);

        // Reset during the write phase of the third block
        clearMon();
        startCp(48);
        n = 0;
        while (!(oWrEn_OutBuf && oWrAddr_OutBuf == 9'd9) && n < 200) begin @(negedge iClk); #1; n++; end
        check("midwr_reached", {31'd0, oWrEn_OutBuf}, 32'd1);
        #1 iRsn = 1'b0;
        #1 checkOutputsZero("midwr_rst");
        repeat (4) @(negedge iClk);
        #1;
        $display("txn reset-abort size=48 writes=%0d done=%0d", wrCnt, doneCnt);
        check("midwr_nodone", 32'(doneCnt), 32'd0);
        iRsn = 1'b1;

        clearMon();
        startCp(16);
        waitDone("recover");
        $display("txn recover size=16 reads=%0d writes=%0d done=%0d", rdCnt, wrCnt, doneCnt);
        check("rec_donecnt", 32'(doneCnt), 32'd1);
        check("rec_writes",  32'(wrCnt),   32'd4);
        check("rec_out0", outBuf[0], 32'hEEEEEEEE);
        check("rec_out1", outBuf[1], 32'hDDDDDDDD);
        check("rec_out2", outBuf[2], 32'hCCCCCCCC);
        check("rec_out3", outBuf[3], 32'hBBBBBBBB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_dt_cp.md
AES_DT_CP -- requirements
Module: aes_dt_cp

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, buffer word-address width (512 words).
REQ-002 SHALL have parameter SIZE_W, default 12, byte-count width.
REQ-003 SHALL have port iClk  input  1  rising-edge clock.
REQ-004 SHALL have port iRsn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports iStCp  input  1 (start pulse) and iCpByteSize  input  SIZE_W (byte count, sampled on start).
REQ-006 SHALL have port oCpDone  output  1  one-cycle completion pulse to the APB interrupt logic.
REQ-007 SHALL have port oBusy  output  1  high from accepted start to done.
REQ-008 SHALL have InBuf read ports oRdEn_InBuf  output  1, oRdAddr_InBuf  output  ADDR_W, iRdDt_InBuf  input  32.
REQ-009 SHALL have OutBuf write ports oWrEn_OutBuf  output  1, oWrAddr_OutBuf  output  ADDR_W, oWrDt_OutBuf  output  32.
REQ-010 SHALL have AES-core ports oAesInVld  output  1, iAesInRdy  input  1, oAesInDt  output  128, iAesOutVld  input  1, iAesOutDt  input  128.

Function
REQ-011 SHALL run FSM states IDLE, RD, AES_REQ, AES_WAIT, WR, DONE.
REQ-012 SHALL, in IDLE on iStCp=1, latch iCpByteSize, compute blocks = ceil(size/16), clear block index, assert oBusy, enter RD.
REQ-013 SHALL clamp sizes above 2048 bytes to 128 blocks.
REQ-014 SHALL, for size 0, go straight to DONE without any buffer or AES access.
REQ-015 SHALL ignore iStCp while oBusy=1.
REQ-016 SHALL, in RD, assert oRdEn_InBuf for 4 consecutive cycles at addresses 4*blk+0..3; InBuf read latency is 1 cycle, so data is captured the cycle after each read.
REQ-017 SHALL pack word k (address 4*blk+k) into oAesInDt[32k+31:32k].
REQ-018 SHALL, the cycle after the 4th capture, enter AES_REQ and hold oAesInVld=1 with stable oAesInDt until iAesInRdy=1; transfer occurs on the cycle both are high.
REQ-019 SHALL, in AES_WAIT, capture iAesOutDt on the first cycle iAesOutVld=1; iAesOutVld outside AES_WAIT is ignored.
REQ-020 SHALL, in WR, assert oWrEn_OutBuf for 4 consecutive cycles, writing iAesOutDt[32k+31:32k] to address 4*blk+k, k=0..3.
REQ-021 SHALL, after the 4th write, increment blk and return to RD if blk < blocks, else enter DONE.
REQ-022 SHALL, in DONE, pulse oCpDone for exactly one cycle, deassert oBusy the same cycle, return to IDLE.
REQ-023 SHALL never assert oRdEn_InBuf and oWrEn_OutBuf in the same cycle.
REQ-024 SHALL drive all address/data outputs to 0 when their enable is low.

Reset
REQ-025 SHALL, on iRsn=0 (asynchronous), force IDLE and drive oCpDone, oBusy, oRdEn_InBuf, oWrEn_OutBuf, oAesInVld, all addresses and data to 0.
REQ-026 SHALL abandon any operation in progress on reset without issuing oCpDone.

Configuration
REQ-027 SHALL, when CP_BYPASS_EN is defined, add input iBypass (sampled on start); with iBypass=1, RD data goes directly to WR, skipping AES_REQ/AES_WAIT and leaving oAesInVld=0.
REQ-028 SHALL, when CP_BYPASS_EN is undefined, have no iBypass port and always route through the AES core.

Structure
REQ-029 SHALL place the FSM state enum, WORDS_PER_BLK=4, BYTES_PER_BLK=16 and MAX_BLOCKS=128 in shared package aes_cp_pkg.
REQ-030 SHALL implement the 4x32-to-128 capture register as sub-module aes_cp_word_pack.

Verification
REQ-031 Size 16, InBuf[0..3]=11111111,22222222,33333333,44444444, AES model returns input XOR all-ones -> OutBuf[0..3]=EEEEEEEE,DDDDDDDD,CCCCCCCC,BBBBBBBB, one oCpDone pulse.
REQ-032 Size 33 -> 3 blocks, 12 reads and 12 writes at addresses 0..11, exactly one oCpDone.
REQ-033 Size 0 -> oCpDone pulse within 2 cycles of iStCp, no oRdEn_InBuf, no oAesInVld.
REQ-034 iAesInRdy held low 10 cycles -> oAesInVld and oAesInDt stable throughout; second iStCp during busy ignored.
REQ-035 iRsn low mid-WR of block 2 -> all outputs 0 immediately, no oCpDone; subsequent size-16 start completes normally.
REQ-036 Size 4095 -> clamped to 128 blocks, last write address 511, one oCpDone.
